// File: rtl/dmem_responder.sv
// Data-memory responder for a single-cycle core: word RAM plus a GPIO output
// register, a one-shot countdown timer with done interrupt, and a free-running cycle counter.
module dmem_responder #(
  parameter int unsigned RAM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  input  logic        we,
  output logic [31:0] rd,
  output logic [31:0] gpio_out,
  output logic        timer_irq
);

  localparam int unsigned AW = $clog2(RAM_WORDS);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2:0] SEL_GPIO   = 3'd0;
  localparam logic [2:0] SEL_LOAD   = 3'd1;
  localparam logic [2:0] SEL_COUNT  = 3'd2;
  localparam logic [2:0] SEL_STATUS = 3'd3;
  localparam logic [2:0] SEL_CYCLE  = 3'd4;

  logic [31:0]   mem [RAM_WORDS];
  logic [AW-1:0] ram_idx;
  logic [2:0]    sel;
  logic          periph;
  logic          gpio_we, load_we, clear_we;

  logic [1:0]  state_q, state_d;
  logic [31:0] count_q, count_d;
  logic [31:0] gpio_q, gpio_d;
  logic [31:0] cycle_q, cycle_d;
  logic        irq_q;

  // Address bits outside the decoded fields are don't-care by design.
  logic unused_addr;
  assign unused_addr = ^{addr[31:12], addr[10:AW+2], addr[1:0]};

  assign ram_idx  = addr[AW+1:2];
  assign sel      = addr[4:2];
  assign periph   = addr[11];
  assign gpio_we  = we & periph & (sel == SEL_GPIO);
  assign load_we  = we & periph & (sel == SEL_LOAD);
  assign clear_we = we & periph & (sel == SEL_STATUS) & wd[0];

  // RAM has no reset; stores during reset are dropped.
  always_ff @(posedge clk) begin
    if (!rst && we && !periph) begin
      mem[ram_idx] <= wd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      gpio_q  <= '0;
      cycle_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      gpio_q  <= gpio_d;
      cycle_q <= cycle_d;
      irq_q   <= (state_d == ST_DONE);
    end
  end

  // Next-state logic; a TIMER_LOAD write overrides whatever the timer was doing.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    gpio_d  = gpio_q;
    cycle_d = cycle_q + 32'd1;
    if (gpio_we) begin
      gpio_d = wd;
    end
    if (load_we) begin
      count_d = wd;
      state_d = (wd != 32'd0) ? ST_RUN : ST_DONE;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_RUN: begin
          count_d = count_q - 32'd1;
          if (count_q == 32'd1) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          if (clear_we) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Combinational read path so the core sees load data in the same cycle.
  always_comb begin
    rd = '0;
    if (!periph) begin
      rd = mem[ram_idx];
    end else begin
      case (sel)
        SEL_GPIO:   rd = gpio_q;
        SEL_COUNT:  rd = count_q;
        SEL_STATUS: rd = {30'd0, state_q == ST_RUN, state_q == ST_DONE};
        SEL_CYCLE:  rd = cycle_q;
        default:    rd = '0;
      endcase
    end
  end

  assign gpio_out  = gpio_q;
  assign timer_irq = irq_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, forced CYCLE wrap, and a
// randomized run checked against a behavioural model of the memory map.
module tb_dmem_responder;

  localparam int unsigned RAM_WORDS = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wd;
  logic        we;
  logic [31:0] rd;
  logic [31:0] gpio_out;
  logic        timer_irq;

  int errs   = 0;
  int checks = 0;

  dmem_responder #(.RAM_WORDS(RAM_WORDS)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wd(wd), .we(we),
    .rd(rd), .gpio_out(gpio_out), .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic [31:0] exp_gpio;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic c, input logic [31:0] e_rd, input logic [31:0] e_gpio,
                     input logic e_irq);
    vec_t v;
    v.rst = r; v.we = w; v.addr = a; v.wd = d;
    v.chk_rd = c; v.exp_rd = e_rd; v.exp_gpio = e_gpio; v.exp_irq = e_irq;
    vecs.push_back(v);
  endtask

  // rd is checked before the edge (old state), gpio/irq after it (new state).
  task automatic apply(input int i, input vec_t v);
    rst = v.rst; we = v.we; addr = v.addr; wd = v.wd;
    #1;
    if (v.chk_rd) chk($sformatf("row%0d rd", i), rd, v.exp_rd);
    @(posedge clk); #1;
    chk($sformatf("row%0d gpio", i), gpio_out, v.exp_gpio);
    chk($sformatf("row%0d irq", i), 32'(timer_irq), 32'(v.exp_irq));
  endtask

  // Behavioural model of the memory map
  logic [31:0] m_ram [int];
  logic [31:0] m_gpio, m_count, m_cycle;
  bit          m_run, m_done;

  task automatic mdl_reset();
    m_gpio = 0; m_count = 0; m_cycle = 0; m_run = 0; m_done = 0;
  endtask

  task automatic mdl_edge(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    int s;
    if (r) begin
      mdl_reset();
      return;
    end
    s = int'((a >> 2) % 8);
    if (w && !a[11]) m_ram[int'((a >> 2) % RAM_WORDS)] = d;
    if (w && a[11] && s == 0) m_gpio = d;
    if (w && a[11] && s == 1) begin
      m_count = d;
      m_run   = (d != 0);
      m_done  = (d == 0);
    end else if (m_run) begin
      m_count = m_count - 1;
      if (m_count == 0) begin
        m_run = 0; m_done = 1;
      end
    end else if (m_done && w && a[11] && s == 3 && d[0]) begin
      m_done = 0;
    end
    m_cycle = m_cycle + 1;
  endtask

  function automatic bit mdl_read(input logic [31:0] a, output logic [31:0] v);
    int s = int'((a >> 2) % 8);
    v = 0;
    if (!a[11]) begin
      if (!m_ram.exists(int'((a >> 2) % RAM_WORDS))) return 0;
      v = m_ram[int'((a >> 2) % RAM_WORDS)];
      return 1;
    end
    case (s)
      0: v = m_gpio;
      2: v = m_count;
      3: v = {30'd0, m_run, m_done};
      4: v = m_cycle;
      default: v = 0;
    endcase
    return 1;
  endfunction

  initial begin
    logic [31:0] ev;
    rst = 1'b1; we = 1'b0; addr = '0; wd = '0;

    // reset, CYCLE from reset, RAM store/load and aliasing
    add(1, 0, 32'h0000_0000, 0,            0, 0,            0, 0);
    add(1, 0, 32'h0000_0000, 0,            0, 0,            0, 0);
    add(0, 0, 32'h0000_0810, 0,            1, 0,            0, 0);
    add(0, 0, 32'h0000_0810, 0,            1, 1,            0, 0);
    add(0, 1, 32'h0000_0810, 32'h1234,     1, 2,            0, 0);
    add(0, 0, 32'h0000_0810, 0,            1, 3,            0, 0);
    add(0, 1, 32'h0000_0010, 32'h1111_1111, 0, 0,           0, 0);
    add(0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 1, 32'h1111_1111, 0, 0);
    add(0, 0, 32'h0000_0010, 0,            1, 32'hDEAD_BEEF, 0, 0);
    add(0, 0, 32'h0000_0110, 0,            1, 32'hDEAD_BEEF, 0, 0);
    add(0, 0, 32'hFFFF_F013, 0,            1, 32'hDEAD_BEEF, 0, 0);
    // GPIO and reserved / read-zero registers
    add(0, 1, 32'h0000_0800, 32'hA5,       1, 0,            32'hA5, 0);
    add(0, 0, 32'h0000_0800, 0,            1, 32'hA5,       32'hA5, 0);
    add(0, 0, 32'h0000_1800, 0,            1, 32'hA5,       32'hA5, 0);
    add(0, 1, 32'h0000_0814, 32'hFFFF_FFFF, 1, 0,           32'hA5, 0);
    add(0, 0, 32'h0000_0818, 0,            1, 0,            32'hA5, 0);
    add(0, 0, 32'h0000_081C, 0,            1, 0,            32'hA5, 0);
    add(0, 0, 32'h0000_0804, 0,            1, 0,            32'hA5, 0);
    add(0, 0, 32'h0000_080C, 0,            1, 0,            32'hA5, 0);
    // timer countdown from 3, done, RO write, clear
    add(0, 1, 32'h0000_0804, 3,            1, 0,            32'hA5, 0);
    add(0, 0, 32'h0000_0808, 0,            1, 3,            32'hA5, 0);
    add(0, 0, 32'h0000_0808, 0,            1, 2,            32'hA5, 0);
    add(0, 0, 32'h0000_0808, 0,            1, 1,            32'hA5, 1);
    add(0, 0, 32'h0000_0808, 0,            1, 0,            32'hA5, 1);
    add(0, 0, 32'h0000_080C, 0,            1, 1,            32'hA5, 1);
    add(0, 1, 32'h0000_0808, 77,           1, 0,            32'hA5, 1);
    add(0, 0, 32'h0000_0808, 0,            1, 0,            32'hA5, 1);
    add(0, 1, 32'h0000_080C, 1,            1, 1,            32'hA5, 0);
    add(0, 0, 32'h0000_080C, 0,            1, 0,            32'hA5, 0);
    // load 0, restart from DONE, reload mid-run, ignored clear in RUN
    add(0, 1, 32'h0000_0804, 0,            1, 0,            32'hA5, 1);
    add(0, 0, 32'h0000_080C, 0,            1, 1,            32'hA5, 1);
    add(0, 1, 32'h0000_0804, 5,            1, 0,            32'hA5, 0);
    add(0, 0, 32'h0000_0808, 0,            1, 5,            32'hA5, 0);
    add(0, 0, 32'h0000_0808, 0,            1, 4,            32'hA5, 0);
    add(0, 0, 32'h0000_0808, 0,            1, 3,            32'hA5, 0);
    add(0, 1, 32'h0000_0804, 5,            1, 0,            32'hA5, 0);
    add(0, 0, 32'h0000_0808, 0,            1, 5,            32'hA5, 0);
    add(0, 1, 32'h0000_080C, 1,            1, 2,            32'hA5, 0);
    add(0, 0, 32'h0000_080C, 0,            1, 2,            32'hA5, 0);
    // reset at count 2 aborts the countdown
    add(1, 0, 32'h0000_0808, 0,            1, 2,            0, 0);
    add(0, 0, 32'h0000_0808, 0,            1, 0,            0, 0);
    add(0, 0, 32'h0000_080C, 0,            1, 0,            0, 0);
    add(0, 0, 32'h0000_080C, 0,            1, 0,            0, 0);
    add(0, 0, 32'h0000_080C, 0,            1, 0,            0, 0);
    add(0, 0, 32'h0000_0800, 0,            1, 0,            0, 0);
    add(0, 0, 32'h0000_0810, 0,            1, 5,            0, 0);
    // store during reset is dropped
    add(1, 1, 32'h0000_0800, 32'hFF,       1, 0,            0, 0);
    add(0, 0, 32'h0000_0800, 0,            1, 0,            0, 0);

    foreach (vecs[i]) apply(i, vecs[i]);

    // CYCLE wrap from a forced 0xFFFFFFFF
    rst = 0; we = 0; addr = 32'h0000_0810;
    force dut.cycle_q = 32'hFFFF_FFFF;
    #1;
    chk("cycle forced", rd, 32'hFFFF_FFFF);
    release dut.cycle_q;
    @(posedge clk); #1;
    chk("cycle wrap", rd, 32'h0000_0000);

    // randomized traffic against the model
    rst = 1; we = 0;
    @(posedge clk); #1;
    mdl_reset();
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a, d;
      logic        w, r;
      a = $urandom();
      if ($urandom_range(0, 1) == 0) begin
        a[11]  = 1'b0;
        a[7:2] = 6'($urandom_range(0, 7));
      end else begin
        a[11]  = 1'b1;
        a[4:2] = 3'($urandom_range(0, 7));
      end
      d = (a[11] && a[4:2] == 3'd1) ? 32'($urandom_range(0, 5)) : $urandom();
      w = ($urandom_range(0, 9) < 4);
      r = ($urandom_range(0, 199) == 0);
      rst = r; we = w; addr = a; wd = d;
      #1;
      if (mdl_read(a, ev)) chk($sformatf("rand%0d rd @%h", n, a), rd, ev);
      @(posedge clk);
      mdl_edge(r, w, a, d);
      #1;
      chk($sformatf("rand%0d gpio", n), gpio_out, m_gpio);
      chk($sformatf("rand%0d irq", n), 32'(timer_irq), 32'(m_done));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
